axi4lite_bridge_port: RTL

AXI4LITE_BRIDGE_PORT -- requirements
Module: axi4lite_bridge_port

---
 rtl/sw_axi_pkg.sv | 20 ++
 rtl/axi4lite_bridge_port.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sw_axi_pkg.sv
// Shared AXI4-Lite definitions: response codes and the bridge-port FSM state
// encoding. Imported by every sw_axi block.
package sw_axi_pkg;

  // AXI4-Lite response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Bridge-port transaction FSM: one transaction in flight at a time.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_BRESP = 3'd3,
    ST_RRESP = 3'd4
  } state_e;

endpackage

// File: rtl/axi4lite_bridge_port.sv
// AXI4-Lite slave port that serialises AW/W and AR traffic into a single
// request/response stream toward a bridge, one transaction outstanding.
//
// Optional feature: define SW_AXI_TIMEOUT_EN to bound the WAIT state. After
// TIMEOUT_CYCLES cycles without rsp_valid the transaction completes with
// SLVERR (rdata = 0) and exactly one late rsp_valid is later swallowed in IDLE.
//
// Handshake rule for every channel: a transfer happens on the rising clk edge
// where valid and ready are both high; the valid side holds valid and its
// payload stable until that edge and never waits on ready to raise valid.
module axi4lite_bridge_port
  import sw_axi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  // AW channel
  input  logic                      s_awvalid,
  output logic                      s_awready,
  input  logic [ADDR_WIDTH-1:0]     s_awaddr,
  input  logic [2:0]                s_awprot,
  // W channel
  input  logic                      s_wvalid,
  output logic                      s_wready,
  input  logic [DATA_WIDTH-1:0]     s_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
  // B channel
  output logic                      s_bvalid,
  input  logic                      s_bready,
  output logic [1:0]                s_bresp,
  // AR channel
  input  logic                      s_arvalid,
  output logic                      s_arready,
  input  logic [ADDR_WIDTH-1:0]     s_araddr,
  input  logic [2:0]                s_arprot,
  // R channel
  output logic                      s_rvalid,
  input  logic                      s_rready,
  output logic [DATA_WIDTH-1:0]     s_rdata,
  output logic [1:0]                s_rresp,
  // request toward the bridge
  output logic                      req_valid,
  input  logic                      req_ready,
  output logic                      req_write,
  output logic [ADDR_WIDTH-1:0]     req_addr,
  output logic [2:0]                req_prot,
  output logic [DATA_WIDTH-1:0]     req_data,
  output logic [DATA_WIDTH/8-1:0]   req_strb,
  // response from the bridge
  input  logic                      rsp_valid,
  output logic                      rsp_ready,
  input  logic [DATA_WIDTH-1:0]     rsp_data,
  input  logic [1:0]                rsp_resp
);

  state_e                  state;
  logic                    last_write;   // 1 = previous grant was a write
  logic [1:0]              resp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic                    wr_elig;
  logic                    rd_elig;
  logic                    grant_wr;
  logic                    grant_rd;
  logic                    timed_out;
  logic                    drop_ready;

  // Eligibility and round-robin arbitration between a complete write
  // (AW and W together) and a read; only evaluated in IDLE and out of reset.
  always_comb begin
    wr_elig  = s_awvalid & s_wvalid;
    rd_elig  = s_arvalid;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (!rst && state == ST_IDLE) begin
      grant_wr = wr_elig & (~rd_elig | ~last_write);
      grant_rd = rd_elig & (~wr_elig |  last_write);
    end
  end

  assign s_awready = grant_wr;
  assign s_wready  = grant_wr;
  assign s_arready = grant_rd;

  assign req_valid = (state == ST_REQ);
  assign s_bvalid  = (state == ST_BRESP);
  assign s_rvalid  = (state == ST_RRESP);
  assign s_bresp   = resp_q;
  assign s_rresp   = resp_q;
  assign s_rdata   = rdata_q;

  // WAIT accepts the real response; IDLE may swallow one stale response
  // left over from a timed-out transaction.
  assign rsp_ready = ~rst & ((state == ST_WAIT) | ((state == ST_IDLE) & drop_ready));

`ifdef SW_AXI_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wait_cnt;
  logic             drop_pending;

  // The last WAIT cycle without a response triggers the timeout.
  assign timed_out  = (state == ST_WAIT) & ~rsp_valid &
                      (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign drop_ready = drop_pending;

  // Counts WAIT cycles spent without a response; restarts on entry to WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT && !rsp_valid) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Remembers that a timed-out response is still owed by the bridge and
  // must be discarded when it turns up in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_pending <= 1'b0;
    end else if (timed_out) begin
      drop_pending <= 1'b1;
    end else if (state == ST_IDLE && rsp_valid) begin
      drop_pending <= 1'b0;
    end
  end
`else
  assign timed_out  = 1'b0;
  assign drop_ready = 1'b0;
`endif

  // Transaction FSM plus request/response payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_write <= 1'b0;
      req_write  <= 1'b0;
      req_addr   <= '0;
      req_prot   <= '0;
      req_data   <= '0;
      req_strb   <= '0;
      resp_q     <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_wr) begin
            req_write  <= 1'b1;
            req_addr   <= s_awaddr;
            req_prot   <= s_awprot;
            req_data   <= s_wdata;
            req_strb   <= s_wstrb;
            last_write <= 1'b1;
            state      <= ST_REQ;
          end else if (grant_rd) begin
            req_write  <= 1'b0;
            req_addr   <= s_araddr;
            req_prot   <= s_arprot;
            req_data   <= '0;
            req_strb   <= '0;
            last_write <= 1'b0;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (req_ready) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (rsp_valid) begin
            resp_q <= rsp_resp;
            if (!req_write) begin
              rdata_q <= rsp_data;
            end
            state <= req_write ? ST_BRESP : ST_RRESP;
          end else if (timed_out) begin
            resp_q  <= RESP_SLVERR;
            rdata_q <= '0;
            state   <= req_write ? ST_BRESP : ST_RRESP;
          end
        end
        ST_BRESP: begin
          if (s_bready) begin
            state <= ST_IDLE;
          end
        end
        ST_RRESP: begin
          if (s_rready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
